mem_bus_arbiter: RTL



---
 rtl/mem_bus_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one two-phase (addr_ok / data_ok) memory bus between the fetch port and
// the data port, returning one-cycle completion pulses and per-port stalls.
module mem_bus_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_valid,
    output logic        inst_stall,
    input  logic        data_ce,
    input  logic [3:0]  data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [2:0]  data_size,
    output logic [31:0] data_rdata,
    output logic        data_valid,
    output logic        data_stall,
    input  logic        flush,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    logic [1:0]  state_reg, state_next;
    logic        owner_reg, owner_next;
    logic        last_grant_reg, last_grant_next;
    logic        discard_reg, discard_next;

    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wstrb_reg;
    logic        wr_reg;
    logic [1:0]  size_reg;

    logic [31:0] inst_rdata_reg, data_rdata_reg;
    logic        inst_valid_reg, data_valid_reg;

    logic        inst_pend, data_pend;
    logic        inst_elig, data_elig;
    logic        grant, grant_data;
    logic        complete, deliver;
    logic        size_unused;

    assign size_unused = data_size[2];

    assign inst_pend = inst_req;
    assign data_pend = data_ce | (|data_we);

    // A port whose completion pulse is showing this cycle has already been served.
    assign inst_elig  = inst_pend & ~inst_valid_reg;
    assign data_elig  = data_pend & ~data_valid_reg;
    assign grant_data = data_elig & (~inst_elig | (last_grant_reg == OWN_INST));
    assign grant      = (state_reg == ST_IDLE) & ~flush & (inst_elig | data_elig);

    assign complete = (state_reg == ST_DATA) & bus_data_ok;
    assign deliver  = complete & ~discard_reg & ~flush;

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_grant_next = last_grant_reg;
        discard_next    = discard_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant) begin
                    state_next      = ST_ADDR;
                    owner_next      = grant_data ? OWN_DATA : OWN_INST;
                    last_grant_next = grant_data ? OWN_DATA : OWN_INST;
                    discard_next    = 1'b0;
                end
            end
            ST_ADDR: begin
                if (flush) begin
                    discard_next = 1'b1;
                end
                if (bus_addr_ok) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus_data_ok) begin
                    state_next   = ST_IDLE;
                    discard_next = 1'b0;
                end else if (flush) begin
                    discard_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= OWN_INST;
            last_grant_reg <= OWN_INST;
            discard_reg    <= 1'b0;
            addr_reg       <= 32'd0;
            wdata_reg      <= 32'd0;
            wstrb_reg      <= 4'd0;
            wr_reg         <= 1'b0;
            size_reg       <= 2'd0;
            inst_rdata_reg <= 32'd0;
            data_rdata_reg <= 32'd0;
            inst_valid_reg <= 1'b0;
            data_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_grant_reg <= last_grant_next;
            discard_reg    <= discard_next;

            // Bus fields are frozen from grant until the next grant.
            if (grant) begin
                if (grant_data) begin
                    addr_reg  <= data_addr;
                    wdata_reg <= data_wdata;
                    wstrb_reg <= data_we;
                    wr_reg    <= |data_we;
                    size_reg  <= data_size[1:0];
                end else begin
                    addr_reg  <= inst_addr;
                    wdata_reg <= 32'd0;
                    wstrb_reg <= 4'd0;
                    wr_reg    <= 1'b0;
                    size_reg  <= 2'd2;
                end
            end

            inst_valid_reg <= deliver & (owner_reg == OWN_INST);
            data_valid_reg <= deliver & (owner_reg == OWN_DATA);

            if (deliver && owner_reg == OWN_INST) begin
                inst_rdata_reg <= bus_rdata;
            end
            if (deliver && owner_reg == OWN_DATA && !wr_reg) begin
                data_rdata_reg <= bus_rdata;
            end
        end
    end

    assign bus_req    = (state_reg == ST_ADDR);
    assign bus_wr     = wr_reg;
    assign bus_size   = size_reg;
    assign bus_addr   = addr_reg;
    assign bus_wdata  = wdata_reg;
    assign bus_wstrb  = wstrb_reg;

    assign inst_rdata = inst_rdata_reg;
    assign inst_valid = inst_valid_reg;
    assign data_rdata = data_rdata_reg;
    assign data_valid = data_valid_reg;

    assign inst_stall = inst_pend & ~inst_valid_reg;
    assign data_stall = data_pend & ~data_valid_reg;

endmodule
